uarc_send_engine: RTL and testbench
===================================

# uarc_send_engine

Sender-side UARC bus transaction engine that sits directly downstream of core0's send/kill/incept/stream decode. It accepts one bus operation per request, plus a target-bus mask, and drives the shared global bus signals and the per-bus `sender_enables`. It collects the kind-matched acknowledgements from every targeted bus and reports completion to the core with a success/timeout/abort status and the mask of buses that never acknowledged.

## Interface

- `WORD_MAG`, 5: log2 word width; `WORD_WIDTH = 1 << WORD_MAG`
- `TOTAL_BUSES`, 1: number of UARC buses
- `TIMEOUT_CYCLES`, 0: maximum BUSY cycles per transaction; 0 disables the timeout

Clocking: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request offered
- `req_ready`  out  1  engine can capture a request
- `req_kind`  in  2  0=send, 1=stream, 2=kill, 3=incept
- `req_buses`  in  TOTAL_BUSES  target bus mask
- `req_data`, `req_self_permission`, `req_self_address`, `req_incept_permission`, `req_incept_address`  in  WORD_WIDTH each  payload
- `abort`  in  1  cancel the in-flight transaction
- `global_send`, `global_stream`, `global_kill`, `global_incept`  out  1 each  kind strobes
- `global_data`, `global_self_permission`, `global_self_address`, `global_incept_permission`, `global_incept_address`  out  WORD_WIDTH each  registered payload
- `sender_enables`  out  TOTAL_BUSES  per-bus enable
- `sender_send_acks`, `sender_stream_acks`, `sender_kill_acks`, `sender_incept_acks`  in  TOTAL_BUSES each  per-bus acks
- `done`  out  1  one-cycle completion pulse
- `done_timeout`  out  1  valid with `done`; set when the transaction ended by timeout
- `done_aborted`  out  1  valid with `done`; set when the transaction ended by abort
- `done_failed_buses`  out  TOTAL_BUSES  valid with `done`; buses still pending at the end

## Operation

States:

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture kind, mask and payload; clear the timeout counter.
  - If the mask is zero, go to DONE with success.
  - Otherwise go to BUSY.
- **BUSY**
  - `pending` = captured mask & ~acked.
  - The strobe for the captured kind is 1; the other three strobes are 0.
  - `sender_enables` = `pending`.
  - Each cycle, set `acked |= kind_acks & pending`, where `kind_acks` is the ack vector of the captured kind only.
  - Acks of other kinds, and acks on unselected or already-acked buses, are ignored.
- **BUSY exits**, evaluated each edge in this priority order:
  1. `abort` → DONE, aborted.
  2. `pending` after this cycle's acks is 0 → DONE, success.
  3. `TIMEOUT_CYCLES`≠0 and counter == `TIMEOUT_CYCLES`-1 → DONE, timeout.
  4. Otherwise increment the counter and stay in BUSY.
- **DONE**
  - All strobes and enables are 0; `req_ready`=0.
  - `done`=1 for exactly one cycle with its status bits; `done_failed_buses` = `pending` at exit (0 on success).
  - Then go to IDLE.
- **Payload:** global payload registers hold the last captured value until the next capture. Receivers qualify the payload with the strobes.
- **`abort` outside BUSY** is ignored.
- **Reset** (any state, including mid-transaction): state IDLE; all strobes, enables, `done`, status bits, failed mask and payload registers are 0; counter and acked mask cleared. `req_ready` is 1 from the first cycle after reset.

## Timing

- Capture on edge E (`req_valid`&`req_ready`). The strobe and `sender_enables` are asserted from cycle E+1. `req_ready` is 0 from E+1 until the cycle after DONE.
- Acks are sampled on the edge; a bus acking in cycle k has its enable removed in cycle k+1. A receiver may ack combinationally in the first BUSY cycle.
- Last ack in cycle k: DONE in cycle k+1 (strobes low, `done`=1), IDLE in k+2. Minimum request-to-request spacing is 3 cycles.
- Empty mask: `done` in cycle E+1, no bus activity.
- Timeout: at most `TIMEOUT_CYCLES` BUSY cycles; `done` in the following cycle.
- Counter width is clog2(`TIMEOUT_CYCLES`+1); it never wraps.

## Test plan

1. **Single-bus send.** `TOTAL_BUSES`=4; send with mask 4'b0010 and data 32'hDEADBEEF; bus1 acks on the 2nd BUSY cycle. Required: `global_send`=1 and `sender_enables`=0010 for 2 cycles; `done`=1 one cycle later with timeout=0, aborted=0, failed=0; `req_ready` returns to 1 after that.
2. **Multi-bus, staggered acks.** Kill with mask 1111; acks arrive on bus0, then bus3, then bus1+bus2. Required: enables go 1111 → 1110 → 0110 → 0000 one cycle after each ack; exactly one `done`.
3. **Wrong-kind and unselected acks.** Incept with mask 0001; drive `sender_send_acks`=1111 and `sender_incept_acks`=0010. Required: the engine stays in BUSY and enables remain 0001 until `sender_incept_acks[0]` is asserted.
4. **Timeout.** `TIMEOUT_CYCLES`=5; stream with mask 0011, only bus0 acks. Required: exactly 5 BUSY cycles, then `done` with timeout=1, failed=0010.
5. **Abort with simultaneous ack.** Send with mask 0001; in the same cycle assert `abort` and the bus0 ack. Required: `done` with aborted=1 and failed=0000. Separately, `abort` asserted while in IDLE has no effect.
6. **Reset mid-transaction, then empty mask.** Pulse `reset` in the 3rd BUSY cycle. Required: all outputs 0 next cycle, `req_ready`=1, and no `done` pulse. Then a request with mask 0 → `done` on the next cycle with success and no strobe.

Source files
------------

// File: rtl/uarc_send_engine.sv
// UARC sender-side transaction engine.
// Takes one bus operation plus a target-bus mask, drives the global strobes,
// payload and per-bus enables, then collects the acks of the matching kind.
// Each transaction ends with a one-cycle done pulse carrying its status and
// the mask of buses that never acknowledged.
module uarc_send_engine #(
  parameter int WORD_MAG       = 5,
  parameter int TOTAL_BUSES    = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_kind,
  input  logic [TOTAL_BUSES-1:0]        req_buses,
  input  logic [(1<<WORD_MAG)-1:0]      req_data,
  input  logic [(1<<WORD_MAG)-1:0]      req_self_permission,
  input  logic [(1<<WORD_MAG)-1:0]      req_self_address,
  input  logic [(1<<WORD_MAG)-1:0]      req_incept_permission,
  input  logic [(1<<WORD_MAG)-1:0]      req_incept_address,
  input  logic                          abort,
  output logic                          global_send,
  output logic                          global_stream,
  output logic                          global_kill,
  output logic                          global_incept,
  output logic [(1<<WORD_MAG)-1:0]      global_data,
  output logic [(1<<WORD_MAG)-1:0]      global_self_permission,
  output logic [(1<<WORD_MAG)-1:0]      global_self_address,
  output logic [(1<<WORD_MAG)-1:0]      global_incept_permission,
  output logic [(1<<WORD_MAG)-1:0]      global_incept_address,
  output logic [TOTAL_BUSES-1:0]        sender_enables,
  input  logic [TOTAL_BUSES-1:0]        sender_send_acks,
  input  logic [TOTAL_BUSES-1:0]        sender_stream_acks,
  input  logic [TOTAL_BUSES-1:0]        sender_kill_acks,
  input  logic [TOTAL_BUSES-1:0]        sender_incept_acks,
  output logic                          done,
  output logic                          done_timeout,
  output logic                          done_aborted,
  output logic [TOTAL_BUSES-1:0]        done_failed_buses
);

  localparam int WORD_WIDTH = 1 << WORD_MAG;
  // Counter is kept at least one bit wide so the timeout-disabled build still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic [1:0]               kind_q;
  logic [3:0]               strobe_q;     // {incept, kill, stream, send}
  logic [TOTAL_BUSES-1:0]   pending_q;    // captured mask minus acked buses; drives the enables
  logic [CNT_W-1:0]         cnt_q;
  logic                     ready_q;
  logic                     done_q;
  logic                     timeout_q;
  logic                     aborted_q;
  logic [TOTAL_BUSES-1:0]   failed_q;
  logic [WORD_WIDTH-1:0]    data_q, self_perm_q, self_addr_q, inc_perm_q, inc_addr_q;

  logic [TOTAL_BUSES-1:0]   kind_acks;
  logic [TOTAL_BUSES-1:0]   pending_d;
  logic                     timeout_hit;

  // Pick the ack vector of the captured kind and fold it into the pending mask.
  always_comb begin
    kind_acks = sender_send_acks;
    case (kind_q)
      2'd0: kind_acks = sender_send_acks;
      2'd1: kind_acks = sender_stream_acks;
      2'd2: kind_acks = sender_kill_acks;
      2'd3: kind_acks = sender_incept_acks;
      default: kind_acks = sender_send_acks;
    endcase
    pending_d   = pending_q & ~kind_acks;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= 2'd0;
      strobe_q    <= 4'b0000;
      pending_q   <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      aborted_q   <= 1'b0;
      failed_q    <= '0;
      data_q      <= '0;
      self_perm_q <= '0;
      self_addr_q <= '0;
      inc_perm_q  <= '0;
      inc_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            kind_q      <= req_kind;
            data_q      <= req_data;
            self_perm_q <= req_self_permission;
            self_addr_q <= req_self_address;
            inc_perm_q  <= req_incept_permission;
            inc_addr_q  <= req_incept_address;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
            failed_q    <= '0;
            if (req_buses == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_BUSY;
              pending_q <= req_buses;
              strobe_q  <= 4'b0001 << req_kind;
            end
          end
        end
        S_BUSY: begin
          if (abort || (pending_d == '0) || timeout_hit) begin
            // Abort outranks a same-cycle final ack; failed mask still reflects this cycle's acks.
            state_q   <= S_DONE;
            strobe_q  <= 4'b0000;
            pending_q <= '0;
            done_q    <= 1'b1;
            aborted_q <= abort;
            timeout_q <= !abort && (pending_d != '0);
            failed_q  <= pending_d;
          end else begin
            pending_q <= pending_d;
            if (TIMEOUT_CYCLES != 0) cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          ready_q   <= 1'b1;
          timeout_q <= 1'b0;
          aborted_q <= 1'b0;
          failed_q  <= '0;
        end
        default: begin
          state_q  <= S_IDLE;
          ready_q  <= 1'b1;
          strobe_q <= 4'b0000;
        end
      endcase
    end
  end

  assign req_ready                = ready_q;
  assign global_send              = strobe_q[0];
  assign global_stream            = strobe_q[1];
  assign global_kill              = strobe_q[2];
  assign global_incept            = strobe_q[3];
  assign global_data              = data_q;
  assign global_self_permission   = self_perm_q;
  assign global_self_address      = self_addr_q;
  assign global_incept_permission = inc_perm_q;
  assign global_incept_address    = inc_addr_q;
  assign sender_enables           = pending_q;
  assign done                     = done_q;
  assign done_timeout             = timeout_q;
  assign done_aborted             = aborted_q;
  assign done_failed_buses        = failed_q;

endmodule

// File: tb/tb_uarc_send_engine.sv
// Directed testbench for uarc_send_engine: four buses, 5-cycle timeout.
module tb_uarc_send_engine;

  localparam int NB = 4;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_kind;
  logic [NB-1:0] req_buses;
  logic [W-1:0]  req_data, req_self_permission, req_self_address;
  logic [W-1:0]  req_incept_permission, req_incept_address;
  logic          abort;
  logic          global_send, global_stream, global_kill, global_incept;
  logic [W-1:0]  global_data, global_self_permission, global_self_address;
  logic [W-1:0]  global_incept_permission, global_incept_address;
  logic [NB-1:0] sender_enables;
  logic [NB-1:0] sender_send_acks, sender_stream_acks, sender_kill_acks, sender_incept_acks;
  logic          done, done_timeout, done_aborted;
  logic [NB-1:0] done_failed_buses;

  int vectors = 0;
  int errors  = 0;

  uarc_send_engine #(.WORD_MAG(5), .TOTAL_BUSES(NB), .TIMEOUT_CYCLES(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_buses(req_buses),
    .req_data(req_data), .req_self_permission(req_self_permission),
    .req_self_address(req_self_address), .req_incept_permission(req_incept_permission),
    .req_incept_address(req_incept_address), .abort(abort),
    .global_send(global_send), .global_stream(global_stream),
    .global_kill(global_kill), .global_incept(global_incept),
    .global_data(global_data), .global_self_permission(global_self_permission),
    .global_self_address(global_self_address),
    .global_incept_permission(global_incept_permission),
    .global_incept_address(global_incept_address),
    .sender_enables(sender_enables),
    .sender_send_acks(sender_send_acks), .sender_stream_acks(sender_stream_acks),
    .sender_kill_acks(sender_kill_acks), .sender_incept_acks(sender_incept_acks),
    .done(done), .done_timeout(done_timeout), .done_aborted(done_aborted),
    .done_failed_buses(done_failed_buses)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then stable for the new cycle and inputs may be set.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {global_incept, global_kill, global_stream, global_send};
  endfunction

  task automatic clear_acks();
    sender_send_acks = '0; sender_stream_acks = '0;
    sender_kill_acks = '0; sender_incept_acks = '0;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [NB-1:0] buses, input logic [W-1:0] data);
    req_valid = 1'b1; req_kind = kind; req_buses = buses; req_data = data;
    req_self_permission = data ^ 32'h1111_1111; req_self_address = data ^ 32'h2222_2222;
    req_incept_permission = data ^ 32'h4444_4444; req_incept_address = data ^ 32'h8888_8888;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_kind = 2'd0; req_buses = '0; abort = 1'b0;
    req_data = '0; req_self_permission = '0; req_self_address = '0;
    req_incept_permission = '0; req_incept_address = '0;
    clear_acks();
    step(); step();
    reset = 1'b0;
    vectors++;
    if ({req_ready, strobes(), sender_enables, done, done_timeout, done_aborted, done_failed_buses} !== 16'b1_0000_0000_000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b strobes=%b en=%b done=%b to=%b ab=%b failed=%b, expected ready=1 rest 0",
               req_ready, strobes(), sender_enables, done, done_timeout, done_aborted, done_failed_buses);
    end
    vectors++;
    if (global_data !== 32'h0 || global_incept_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_payload: got data=%h inc_addr=%h, expected 0", global_data, global_incept_address);
    end
  endtask

  task automatic test_single_send();
    issue(2'd0, 4'b0010, 32'hDEADBEEF);
    for (int c = 1; c <= 2; c++) begin
      vectors++;
      if (strobes() !== 4'b0001 || sender_enables !== 4'b0010 || req_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL single_busy%0d: got strobes=%b en=%b ready=%b done=%b, expected 0001 0010 0 0",
                 c, strobes(), sender_enables, req_ready, done);
      end
      if (c == 2) sender_send_acks = 4'b0010;
      step();
    end
    clear_acks();
    vectors++;
    if ({done, done_timeout, done_aborted, done_failed_buses, strobes(), sender_enables, req_ready} !== 16'b1_0_0_0000_0000_0000_0) begin
      errors++;
      $display("FAIL single_done: got done=%b to=%b ab=%b failed=%b strobes=%b en=%b ready=%b, expected 1 0 0 0000 0000 0000 0",
               done, done_timeout, done_aborted, done_failed_buses, strobes(), sender_enables, req_ready);
    end
    vectors++;
    if (global_data !== 32'hDEADBEEF || global_self_address !== 32'hFC8F9CCD || global_incept_permission !== 32'h9AE9FAAB) begin
      errors++;
      $display("FAIL single_payload: got data=%h saddr=%h iperm=%h, expected deadbeef fc8f9ccd 9ae9faab",
               global_data, global_self_address, global_incept_permission);
    end
    step();
    vectors++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got ready=%b done=%b, expected 1 0", req_ready, done);
    end
  endtask

  task automatic test_staggered_kill();
    logic [NB-1:0] acks [3];
    logic [NB-1:0] en_exp [3];
    int dones;
    acks[0] = 4'b0001; acks[1] = 4'b1000; acks[2] = 4'b0110;
    en_exp[0] = 4'b1111; en_exp[1] = 4'b1110; en_exp[2] = 4'b0110;
    dones = 0;
    issue(2'd2, 4'b1111, 32'h0BAD_F00D);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (sender_enables !== en_exp[c] || strobes() !== 4'b0100) begin
        errors++;
        $display("FAIL kill_enables%0d: got en=%b strobes=%b, expected en=%b strobes=0100",
                 c, sender_enables, strobes(), en_exp[c]);
      end
      if (done) dones++;
      sender_kill_acks = acks[c];
      step();
    end
    clear_acks();
    vectors++;
    if (sender_enables !== 4'b0000 || strobes() !== 4'b0000 || done_failed_buses !== 4'b0000) begin
      errors++;
      $display("FAIL kill_final: got en=%b strobes=%b failed=%b, expected 0000 0000 0000",
               sender_enables, strobes(), done_failed_buses);
    end
    for (int c = 0; c < 3; c++) begin
      if (done) dones++;
      step();
    end
    vectors++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL kill_done_count: got %0d done pulses, expected 1", dones);
    end
  endtask

  task automatic test_wrong_kind();
    issue(2'd3, 4'b0001, 32'h1234_5678);
    sender_send_acks = 4'b1111; sender_incept_acks = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (sender_enables !== 4'b0001 || strobes() !== 4'b1000 || done !== 1'b0) begin
        errors++;
        $display("FAIL wrongkind_busy%0d: got en=%b strobes=%b done=%b, expected 0001 1000 0",
                 c, sender_enables, strobes(), done);
      end
      if (c == 4) begin sender_send_acks = '0; sender_incept_acks = 4'b0001; end
      step();
    end
    clear_acks();
    vectors++;
    if ({done, done_timeout, done_aborted, done_failed_buses} !== 7'b1_0_0_0000) begin
      errors++;
      $display("FAIL wrongkind_done: got done=%b to=%b ab=%b failed=%b, expected 1 0 0 0000",
               done, done_timeout, done_aborted, done_failed_buses);
    end
    step();
  endtask

  task automatic test_timeout();
    issue(2'd1, 4'b0011, 32'hCAFE_0001);
    vectors++;
    if (sender_enables !== 4'b0011 || strobes() !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_busy1: got en=%b strobes=%b, expected 0011 0010", sender_enables, strobes());
    end
    sender_stream_acks = 4'b0001;
    step();
    clear_acks();
    for (int c = 2; c <= 5; c++) begin
      vectors++;
      if (sender_enables !== 4'b0010 || done !== 1'b0 || strobes() !== 4'b0010) begin
        errors++;
        $display("FAIL timeout_busy%0d: got en=%b done=%b strobes=%b, expected 0010 0 0010",
                 c, sender_enables, done, strobes());
      end
      step();
    end
    vectors++;
    if ({done, done_timeout, done_aborted, done_failed_buses, strobes()} !== 11'b1_1_0_0010_0000) begin
      errors++;
      $display("FAIL timeout_done: got done=%b to=%b ab=%b failed=%b strobes=%b, expected 1 1 0 0010 0000",
               done, done_timeout, done_aborted, done_failed_buses, strobes());
    end
    step();
  endtask

  task automatic test_abort();
    issue(2'd0, 4'b0001, 32'h0000_00AB);
    abort = 1'b1; sender_send_acks = 4'b0001;
    step();
    abort = 1'b0; clear_acks();
    vectors++;
    if ({done, done_timeout, done_aborted, done_failed_buses} !== 7'b1_0_1_0000) begin
      errors++;
      $display("FAIL abort_done: got done=%b to=%b ab=%b failed=%b, expected 1 0 1 0000",
               done, done_timeout, done_aborted, done_failed_buses);
    end
    step();
    abort = 1'b1;
    step(); step();
    vectors++;
    if (req_ready !== 1'b1 || done !== 1'b0 || strobes() !== 4'b0000 || sender_enables !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got ready=%b done=%b strobes=%b en=%b, expected 1 0 0000 0000",
               req_ready, done, strobes(), sender_enables);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int dones;
    dones = 0;
    issue(2'd0, 4'b0101, 32'h5555_AAAA);
    step(); step();
    vectors++;
    if (sender_enables !== 4'b0101 || strobes() !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_busy3: got en=%b strobes=%b, expected 0101 0001", sender_enables, strobes());
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({req_ready, strobes(), sender_enables, done, done_timeout, done_aborted, done_failed_buses} !== 16'b1_0000_0000_000_0000
        || global_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b strobes=%b en=%b done=%b failed=%b data=%h, expected ready=1 rest 0",
               req_ready, strobes(), sender_enables, done, done_failed_buses, global_data);
    end
    for (int c = 0; c < 3; c++) begin
      if (done) dones++;
      step();
    end
    vectors++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d done pulses, expected 0", dones);
    end
    issue(2'd0, 4'b0000, 32'h7777_0000);
    vectors++;
    if ({done, done_timeout, done_aborted, done_failed_buses, strobes(), sender_enables, req_ready} !== 16'b1_0_0_0000_0000_0000_0) begin
      errors++;
      $display("FAIL empty_done: got done=%b to=%b ab=%b failed=%b strobes=%b en=%b ready=%b, expected 1 0 0 0000 0000 0000 0",
               done, done_timeout, done_aborted, done_failed_buses, strobes(), sender_enables, req_ready);
    end
    step();
    vectors++;
    if (req_ready !== 1'b1 || done !== 1'b0 || global_data !== 32'h7777_0000) begin
      errors++;
      $display("FAIL empty_idle: got ready=%b done=%b data=%h, expected 1 0 77770000", req_ready, done, global_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_staggered_kill();
    test_wrong_kind();
    test_timeout();
    test_abort();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
